// File: rtl/stereo_frame_ctrl_if.sv
// Stream handshake bundle (tdata/tuser/tlast/tvalid/tready) shared by the
// upstream gray stream and the downstream unfolding/SAD stream.
interface stereo_frame_ctrl_if #(
  parameter int DW = 32
);
  logic [DW-1:0] tdata;
  logic          tuser;
  logic          tlast;
  logic          tvalid;
  logic          tready;

  modport master (output tdata, tuser, tlast, tvalid, input tready);
  modport slave  (input tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/stereo_frame_ctrl.sv
// Frame gate between the gray stream and the stereo stage: waits for SOF,
// regenerates tuser/tlast from beat counters, flags framing errors, counts frames.
//
// state    | meaning
// IDLE     | disarmed, input drained and discarded, waiting for start
// WAIT_SOF | armed, dropping beats until one with tuser=1
// PASS     | forwarding beats through one output register
// FLUSH    | aborted, input stalled until the output register drains
module stereo_frame_ctrl #(
  parameter int WIDTH                 = 3840,
  parameter int HEIGHT                = 2160,
  parameter int MAX_SAMPLES_PER_CLOCK = 4,
  parameter int AXIS_TDATA_WIDTH      = 32
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                start,
  input  logic                continuous,
  input  logic                abort,
  stereo_frame_ctrl_if.slave  s_axis,
  stereo_frame_ctrl_if.master m_axis,
  output logic                busy,
  output logic                frame_done,
  output logic                err_eol_early,
  output logic                err_eol_late,
  output logic                err_sof,
  output logic [15:0]         frame_cnt
);

  localparam int BPL = WIDTH / MAX_SAMPLES_PER_CLOCK;
  localparam int CW  = (BPL > 1) ? $clog2(BPL) : 1;
  localparam int RW  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(BPL - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, PASS, FLUSH} state_t;

  state_t                      r_state;
  logic [CW-1:0]               r_col;
  logic [RW-1:0]               r_row;
  logic                        r_mvalid;
  logic                        r_muser;
  logic                        r_mlast;
  logic [AXIS_TDATA_WIDTH-1:0] r_mdata;
  logic                        r_done;
  logic                        r_eol_early;
  logic                        r_eol_late;
  logic                        r_sof_err;
  logic [15:0]                 r_frame_cnt;

  logic          w_out_free;
  logic          w_s_ready;
  logic          w_s_acc;
  logic          w_sof;
  logic          w_fwd;
  logic [CW-1:0] w_eff_col;
  logic [RW-1:0] w_eff_row;
  logic          w_col_last;
  logic          w_row_last;
  logic          w_frame_end;

  assign w_out_free = !r_mvalid || m_axis.tready;

  // WAIT_SOF also honours back-pressure: in continuous mode the last beat of the
  // previous frame may still sit in the output register when the next SOF arrives.
  always_comb begin
    w_s_ready = 1'b0;
    if (!areset) begin
      case (r_state)
        IDLE:           w_s_ready = 1'b1;
        WAIT_SOF, PASS: w_s_ready = w_out_free;
        default:        w_s_ready = 1'b0;
      endcase
    end
  end

  assign w_s_acc     = s_axis.tvalid && w_s_ready;
  assign w_sof       = s_axis.tuser;
  assign w_fwd       = w_s_acc && ((r_state == WAIT_SOF && w_sof && !abort) || r_state == PASS);
  assign w_eff_col   = w_sof ? '0 : r_col;
  assign w_eff_row   = w_sof ? '0 : r_row;
  assign w_col_last  = (w_eff_col == COL_LAST);
  assign w_row_last  = (w_eff_row == ROW_LAST);
  assign w_frame_end = w_fwd && w_col_last && w_row_last;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state     <= IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_mvalid    <= 1'b0;
      r_muser     <= 1'b0;
      r_mlast     <= 1'b0;
      r_mdata     <= '0;
      r_done      <= 1'b0;
      r_eol_early <= 1'b0;
      r_eol_late  <= 1'b0;
      r_sof_err   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_done      <= 1'b0;
      r_eol_early <= 1'b0;
      r_eol_late  <= 1'b0;
      r_sof_err   <= 1'b0;

      if (m_axis.tready) r_mvalid <= 1'b0;

      if (w_fwd) begin
        r_mvalid    <= 1'b1;
        r_mdata     <= s_axis.tdata;
        r_muser     <= w_sof;
        r_mlast     <= w_col_last;
        r_eol_early <= s_axis.tlast && !w_col_last;
        r_eol_late  <= w_col_last && !s_axis.tlast;
        r_sof_err   <= (r_state == PASS) && w_sof && (r_col != '0 || r_row != '0);
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : w_eff_row + 1'b1;
        end else begin
          r_col <= w_eff_col + 1'b1;
          r_row <= w_eff_row;
        end
        if (w_frame_end) begin
          r_done      <= 1'b1;
          r_frame_cnt <= r_frame_cnt + 16'd1;
        end
      end

      case (r_state)
        IDLE: begin
          if (start && !abort) r_state <= WAIT_SOF;
        end
        WAIT_SOF, PASS: begin
          if (abort)            r_state <= FLUSH;
          else if (w_frame_end) r_state <= continuous ? WAIT_SOF : IDLE;
          else if (w_fwd)       r_state <= PASS;
        end
        FLUSH: begin
          if (!r_mvalid) begin
            r_state <= IDLE;
            r_col   <= '0;
            r_row   <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_axis.tvalid = r_mvalid;
  assign m_axis.tuser  = r_muser;
  assign m_axis.tlast  = r_mlast;
  assign m_axis.tdata  = r_mdata;
  assign s_axis.tready = w_s_ready;
  assign busy          = (r_state != IDLE);
  assign frame_done    = r_done;
  assign err_eol_early = r_eol_early;
  assign err_eol_late  = r_eol_late;
  assign err_sof       = r_sof_err;
  assign frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_stereo_frame_ctrl.sv
// Scoreboard bench for stereo_frame_ctrl: a frame-position model predicts every
// output beat and event count; a negedge monitor pops and compares.
module tb_stereo_frame_ctrl;

  localparam int W   = 16;
  localparam int H   = 4;
  localparam int S   = 4;
  localparam int BPL = W / S;
  localparam int FB  = BPL * H;

  typedef struct {
    logic [31:0] data;
    logic        user;
    logic        last;
  } beat_t;

  logic        aclk = 1'b0;
  logic        areset;
  logic        start, continuous, abort;
  logic        busy, frame_done, err_eol_early, err_eol_late, err_sof;
  logic [15:0] frame_cnt;

  stereo_frame_ctrl_if #(.DW(32)) s_if ();
  stereo_frame_ctrl_if #(.DW(32)) m_if ();

  stereo_frame_ctrl #(
    .WIDTH(W), .HEIGHT(H), .MAX_SAMPLES_PER_CLOCK(S), .AXIS_TDATA_WIDTH(32)
  ) dut (
    .aclk(aclk), .areset(areset), .start(start), .continuous(continuous), .abort(abort),
    .s_axis(s_if), .m_axis(m_if),
    .busy(busy), .frame_done(frame_done), .err_eol_early(err_eol_early),
    .err_eol_late(err_eol_late), .err_sof(err_sof), .frame_cnt(frame_cnt)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_bad = 0;
  int rmode = 3;
  int gap_max = 0;

  beat_t exp_q[$];
  int    m_pos = 0;
  bit    m_armed = 0, m_active = 0;
  int    exp_done = 0, exp_eole = 0, exp_eoll = 0, exp_sof = 0, exp_fcnt = 0;
  int    act_done = 0, act_eole = 0, act_eoll = 0, act_sof = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: tracks the position of the next beat within the frame.
  function automatic void model_beat(input logic [31:0] d, input logic u, input logic l);
    bit line_end;
    beat_t b;
    if (!m_armed) return;
    if (!m_active) begin
      if (!u) return;
      m_active = 1;
      m_pos    = 0;
    end else if (u && m_pos != 0) begin
      exp_sof++;
      m_pos = 0;
    end
    line_end = (m_pos % BPL) == BPL - 1;
    b.data = d;
    b.user = (m_pos == 0);
    b.last = line_end;
    exp_q.push_back(b);
    if (l && !line_end) exp_eole++;
    if (line_end && !l) exp_eoll++;
    m_pos++;
    if (m_pos == FB) begin
      exp_done++;
      exp_fcnt = (exp_fcnt + 1) % 65536;
      m_pos    = 0;
      m_active = 0;
      m_armed  = continuous;
    end
  endfunction

  always @(posedge aclk) begin
    #1;
    case (rmode)
      0:       m_if.tready = 1'b1;
      1:       m_if.tready = !m_if.tready;
      2:       m_if.tready = 1'($urandom_range(0, 1));
      default: m_if.tready = 1'b0;
    endcase
  end

  always @(negedge aclk) begin
    beat_t e;
    if (!areset) begin
      if (frame_done)    act_done++;
      if (err_eol_early) act_eole++;
      if (err_eol_late)  act_eoll++;
      if (err_sof)       act_sof++;
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got data %0h expected no beat", m_if.tdata);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", m_if.tdata, e.data);
          check("beat_tuser", 32'(m_if.tuser), 32'(e.user));
          check("beat_tlast", 32'(m_if.tlast), 32'(e.last));
        end
      end
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic u, input logic l);
    int n;
    repeat ($urandom_range(0, gap_max)) begin
      @(posedge aclk);
      #1;
    end
    s_if.tdata  = d;
    s_if.tuser  = u;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    model_beat(d, u, l);
    n = 0;
    @(negedge aclk);
    while (!s_if.tready && n < 200) begin
      n++;
      @(negedge aclk);
    end
    if (!s_if.tready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL s_ready_timeout: got tready 0 expected 1");
    end
    @(posedge aclk);
    #1;
    s_if.tvalid = 1'b0;
  endtask

  task automatic send_frame(input int bad_last);
    logic l;
    for (int k = 0; k < FB; k++) begin
      l = ((k % BPL) == BPL - 1);
      if (bad_last != 0 && $urandom_range(0, 7) == 0) l = !l;
      send_beat($urandom, (k == 0), l);
    end
  endtask

  task automatic pulse_start();
    @(posedge aclk); #1 start = 1'b1;
    @(posedge aclk); #1 start = 1'b0;
    m_armed  = 1;
    m_active = 0;
  endtask

  task automatic pulse_abort();
    @(posedge aclk); #1 abort = 1'b1;
    @(posedge aclk); #1 abort = 1'b0;
    m_armed  = 0;
    m_active = 0;
    m_pos    = 0;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge aclk);
    while ((exp_q.size() != 0 || m_if.tvalid) && n < 500) begin
      n++;
      @(negedge aclk);
    end
    if (exp_q.size() != 0 || m_if.tvalid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
    end
    repeat (3) @(negedge aclk);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge aclk);
    while (busy && n < 200) begin
      n++;
      @(negedge aclk);
    end
    check("return_to_idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_frame_done"}, act_done, exp_done);
    check({tag, "_err_eol_early"}, act_eole, exp_eole);
    check({tag, "_err_eol_late"}, act_eoll, exp_eoll);
    check({tag, "_err_sof"}, act_sof, exp_sof);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), exp_fcnt);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_tvalid"}, 32'(m_if.tvalid), 32'd0);
    check({tag, "_m_tuser_tlast"}, {30'd0, m_if.tuser, m_if.tlast}, 32'd0);
    check({tag, "_m_tdata"}, m_if.tdata, 32'd0);
    check({tag, "_s_tready"}, 32'(s_if.tready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    check({tag, "_pulses"}, {28'd0, frame_done, err_eol_early, err_eol_late, err_sof}, 32'd0);
  endtask

  initial begin
    logic l;
    areset      = 1'b1;
    start       = 1'b0;
    continuous  = 1'b0;
    abort       = 1'b0;
    s_if.tdata  = '0;
    s_if.tuser  = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tvalid = 1'b0;
    #22;
    check_reset_outputs("por");
    @(posedge aclk); #1 areset = 1'b0;
    rmode = 0;
    @(negedge aclk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_s_tready", 32'(s_if.tready), 32'd1);

    // junk before SOF, then a clean frame at full rate
    pulse_start();
    for (int j = 0; j < 3; j++) send_beat($urandom, 1'b0, 1'b0);
    send_frame(0);
    drain();
    check_counts("clean");
    check("clean_busy", 32'(busy), 32'd0);

    // two back-to-back frames in continuous mode, toggling ready
    continuous = 1'b1;
    rmode = 1;
    pulse_start();
    send_frame(0);
    send_frame(0);
    drain();
    check_counts("cont");
    check("cont_wait_sof_busy", 32'(busy), 32'd1);
    continuous = 1'b0;
    pulse_abort();
    wait_idle();

    // early tlast on beat 1, missing tlast on beat 7
    rmode = 0;
    pulse_start();
    for (int k = 0; k < FB; k++) begin
      l = ((k % BPL) == BPL - 1);
      if (k == 1) l = 1'b1;
      if (k == 7) l = 1'b0;
      send_beat($urandom, (k == 0), l);
    end
    drain();
    check_counts("eol");

    // SOF re-sync on beat 6, frame completes 16 beats from there
    pulse_start();
    for (int k = 0; k < 6; k++) send_beat($urandom, (k == 0), ((k % BPL) == BPL - 1));
    send_frame(0);
    drain();
    check_counts("resync");

    // randomized back-pressure, gaps, junk and tlast corruption
    rmode   = 2;
    gap_max = 2;
    for (int it = 0; it < 4; it++) begin
      pulse_start();
      repeat ($urandom_range(0, 2)) send_beat($urandom, 1'b0, 1'($urandom_range(0, 1)));
      send_frame(1);
      drain();
      check_counts("rand");
    end
    gap_max = 0;

    // abort with a beat held in the output register
    rmode = 0;
    pulse_start();
    for (int k = 0; k < 5; k++) send_beat($urandom, (k == 0), ((k % BPL) == BPL - 1));
    drain();
    rmode = 3;
    @(posedge aclk); #1;
    send_beat($urandom, 1'b0, 1'b0);
    pulse_abort();
    @(negedge aclk);
    check("flush_s_tready", 32'(s_if.tready), 32'd0);
    check("flush_busy", 32'(busy), 32'd1);
    check("flush_held_valid", 32'(m_if.tvalid), 32'd1);
    repeat (3) @(negedge aclk);
    check("flush_still_busy", 32'(busy), 32'd1);
    rmode = 0;
    wait_idle();
    drain();
    check_counts("abort");

    // reset mid-frame with a beat held in the output register
    pulse_start();
    for (int k = 0; k < 8; k++) send_beat($urandom, (k == 0), ((k % BPL) == BPL - 1));
    drain();
    rmode = 3;
    @(posedge aclk); #1;
    send_beat($urandom, 1'b0, 1'b0);
    @(posedge aclk);
    #3 areset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    exp_fcnt = 0;
    m_armed  = 0;
    m_active = 0;
    m_pos    = 0;
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    rmode = 0;
    @(negedge aclk);
    check("post_rst_busy", 32'(busy), 32'd0);
    pulse_start();
    send_frame(0);
    drain();
    check_counts("post_rst");

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
